// File: rtl/jtvigil_ioregs_if.sv
// Z80 I/O bus as seen by the main-CPU register file.
// The CPU wrapper drives it; the register file only listens.
interface jtvigil_ioregs_if;
  logic [7:0] A;
  logic       iorq_n;
  logic       wr_n;
  logic       m1_n;
  logic [7:0] din;

  modport master (output A, iorq_n, wr_n, m1_n, din);
  modport slave  (input  A, iorq_n, wr_n, m1_n, din);
endinterface

// File: rtl/jtvigil_ioregs.sv
// Z80 I/O register file: bank, flip and vblank-latched scroll channels,
// plus the vertical-blank interrupt with acknowledge.

module jtvigil_ioregs_chan #(
  parameter int POSW    = 11,
  parameter int VBLATCH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_lo,
  input  logic            we_hi,
  input  logic [7:0]      din_lo,
  input  logic [POSW-9:0] din_hi,
  input  logic            commit,
  output logic [POSW-1:0] pos
);
  logic [POSW-1:0] shadow;
  logic            pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      pend   <= 1'b0;
      pos    <= '0;
    end else begin
      if (we_lo) shadow[7:0]      <= din_lo;
      if (we_hi) shadow[POSW-1:8] <= din_hi;
      // A write on the commit cycle wins over the clear, so it lands next frame
      if (we_lo || we_hi) pend <= 1'b1;
      else if (commit)    pend <= 1'b0;
      if (VBLATCH == 0)          pos <= shadow;
      else if (commit && pend)   pos <= shadow;
    end
  end
endmodule

module jtvigil_ioregs #(
  parameter int SCRN    = 2,
  parameter int POSW    = 11,
  parameter int BANKW   = 3,
  parameter int VBLATCH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtvigil_ioregs_if.slave      bus,
  input  logic                 LVBL,
  input  logic                 dip_pause,
  input  logic                 dip_flip,
  output logic [BANKW-1:0]     bank,
  output logic                 flip,
  output logic [SCRN*POSW-1:0] scrpos,
  output logic [2:0]           scrcol,
  output logic                 int_n
);
  localparam logic [6:0] COLPORT = 7'(2*SCRN);

  typedef enum logic {IDLE, REQ} int_st_t;

  logic                      wr_s, wr_l, wr_acc;
  logic                      lvbl_l, vb_edge, ack;
  logic                      flipr;
  logic [2:0]                colsh;
  logic                      pend_col;
  logic [SCRN-1:0]           we_lo, we_hi;
  logic [SCRN-1:0][POSW-1:0] pos_q;
  int_st_t                   st, st_nx;

  assign wr_s    = !bus.iorq_n && !bus.wr_n && bus.m1_n;
  assign wr_acc  = wr_s && !wr_l;
  assign vb_edge = lvbl_l && !LVBL;
  assign ack     = !bus.m1_n && !bus.iorq_n;

  // wr_l resets high so a strobe held across reset release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_l   <= 1'b1;
      lvbl_l <= 1'b1;
    end else begin
      wr_l   <= wr_s;
      lvbl_l <= LVBL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank     <= '0;
      flipr    <= 1'b0;
      flip     <= 1'b0;
      colsh    <= '0;
      pend_col <= 1'b0;
      scrcol   <= '0;
    end else begin
      flip <= flipr ^ dip_flip;
      if (wr_acc && !bus.A[7]) begin
        if (bus.A[2:0] == 3'd1) flipr <= bus.din[0];
        if (bus.A[2:0] == 3'd4) bank  <= bus.din[BANKW-1:0];
      end
      if (wr_acc && bus.A[7] && bus.A[6:0] == COLPORT) begin
        colsh    <= {bus.din[3], bus.din[1:0]};
        pend_col <= 1'b1;
      end else if (vb_edge) begin
        pend_col <= 1'b0;
      end
      if (VBLATCH == 0)            scrcol <= colsh;
      else if (vb_edge && pend_col) scrcol <= colsh;
    end
  end

  genvar k;
  generate
    for (k = 0; k < SCRN; k++) begin : g_chan
      assign we_lo[k] = wr_acc && bus.A[7] && bus.A[6:1] == 6'(k) && !bus.A[0];
      assign we_hi[k] = wr_acc && bus.A[7] && bus.A[6:1] == 6'(k) &&  bus.A[0];

      jtvigil_ioregs_chan #(.POSW(POSW), .VBLATCH(VBLATCH)) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_lo  (we_lo[k]),
        .we_hi  (we_hi[k]),
        .din_lo (bus.din),
        .din_hi (bus.din[POSW-9:0]),
        .commit (vb_edge),
        .pos    (pos_q[k])
      );
    end
  endgenerate

  assign scrpos = pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // Request is dropped if vblank ends before the CPU acknowledges it
  always_comb begin
    st_nx = st;
    case (st)
      IDLE: if (vb_edge && dip_pause)        st_nx = REQ;
      REQ:  if (ack || LVBL || !dip_pause)   st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign int_n = (st != REQ);
endmodule

// File: tb/tb_jtvigil_ioregs.sv
// Randomised bench for jtvigil_ioregs against a frame-level reference model.
// Two instances share the bus: vblank-latched (POSW=11) and free-running (POSW=9).
module tb_jtvigil_ioregs;
  localparam int SCRN = 2;

  logic clk = 1'b0;
  logic rst_n, lvbl, dip_pause, dip_flip;
  logic [2:0]  bank1, bank2, scrcol1, scrcol2;
  logic        flip1, flip2, int1, int2;
  logic [21:0] scrpos1;
  logic [17:0] scrpos2;

  int n_chk = 0;
  int n_err = 0;

  jtvigil_ioregs_if bus();

  jtvigil_ioregs #(.SCRN(SCRN), .POSW(11), .BANKW(3), .VBLATCH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .LVBL(lvbl),
    .dip_pause(dip_pause), .dip_flip(dip_flip), .bank(bank1), .flip(flip1),
    .scrpos(scrpos1), .scrcol(scrcol1), .int_n(int1));

  jtvigil_ioregs #(.SCRN(SCRN), .POSW(9), .BANKW(3), .VBLATCH(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .LVBL(lvbl),
    .dip_pause(dip_pause), .dip_flip(dip_flip), .bank(bank2), .flip(flip2),
    .scrpos(scrpos2), .scrcol(scrcol2), .int_n(int2));

  always #5 clk = ~clk;

  // reference model state
  bit m_wl, m_lv, m_flipr, m_flip, m_pcol, m_req;
  int m_bank, m_colsh, m_col, m_col2;
  int m_sh[SCRN], m_pos[SCRN], m_sh2[SCRN], m_pos2[SCRN];
  bit m_pend[SCRN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_wl = 1; m_lv = 1; m_flipr = 0; m_flip = 0; m_pcol = 0; m_req = 0;
    m_bank = 0; m_colsh = 0; m_col = 0; m_col2 = 0;
    for (int k = 0; k < SCRN; k++) begin
      m_sh[k] = 0; m_pos[k] = 0; m_sh2[k] = 0; m_pos2[k] = 0; m_pend[k] = 0;
    end
  endtask

  task automatic model_step();
    bit ws, acc, vbe, ack;
    int a, d, p, k;
    ws  = !bus.iorq_n && !bus.wr_n && bus.m1_n;
    ack = !bus.m1_n && !bus.iorq_n;
    acc = ws && !m_wl;
    m_wl = ws;
    vbe = m_lv && !lvbl;
    m_lv = lvbl;
    m_flip = m_flipr ^ dip_flip;
    // free-running instance shows last cycle's shadow
    for (int i = 0; i < SCRN; i++) m_pos2[i] = m_sh2[i];
    m_col2 = m_colsh;
    // vblank commit sees the shadows as they were before any write this cycle
    if (vbe) begin
      for (int i = 0; i < SCRN; i++)
        if (m_pend[i]) begin m_pos[i] = m_sh[i]; m_pend[i] = 0; end
      if (m_pcol) begin m_col = m_colsh; m_pcol = 0; end
    end
    if (m_req) begin
      if (ack || lvbl || !dip_pause) m_req = 0;
    end else if (vbe && dip_pause) m_req = 1;
    if (acc) begin
      a = int'(bus.A); d = int'(bus.din);
      if (a < 128) begin
        if (a % 8 == 1) m_flipr = d[0];
        else if (a % 8 == 4) m_bank = d % 8;
      end else begin
        p = a - 128;
        if (p < 2*SCRN) begin
          k = p / 2;
          if (p % 2 == 0) begin
            m_sh[k]  = (m_sh[k]  / 256) * 256 + d;
            m_sh2[k] = (m_sh2[k] / 256) * 256 + d;
          end else begin
            m_sh[k]  = (m_sh[k]  % 256) + (d % 8) * 256;
            m_sh2[k] = (m_sh2[k] % 256) + (d % 2) * 256;
          end
          m_pend[k] = 1;
        end else if (p == 2*SCRN) begin
          m_colsh = (d[3] ? 4 : 0) + d % 4;
          m_pcol = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("bank",    32'(bank1),   32'(m_bank));
    chk("flip",    32'(flip1),   32'(m_flip));
    chk("scrpos",  32'(scrpos1), 32'(m_pos[0] + m_pos[1] * 2048));
    chk("scrcol",  32'(scrcol1), 32'(m_col));
    chk("int_n",   32'(int1),    32'(!m_req));
    chk("bank2",   32'(bank2),   32'(m_bank));
    chk("flip2",   32'(flip2),   32'(m_flip));
    chk("scrpos2", 32'(scrpos2), 32'(m_pos2[0] + m_pos2[1] * 512));
    chk("scrcol2", 32'(scrcol2), 32'(m_col2));
    chk("int_n2",  32'(int2),    32'(!m_req));
  endtask

  // one clock: model advances on the edge, DUT sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1; bus.wr_n = 1; bus.m1_n = 1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus.A = a; bus.din = d; bus.iorq_n = 0; bus.wr_n = 0; bus.m1_n = 1;
  endtask

  task automatic wr_port(input logic [7:0] a, input logic [7:0] d, input int len);
    bus_wr(a, d);
    repeat (len) cyc();
    bus_idle();
    cyc();
  endtask

  logic [7:0] ports [13] = '{8'h01, 8'h09, 8'h04, 8'h0C, 8'h05, 8'h80, 8'h81,
                             8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h00};

  initial begin
    int wr_left, lv_cnt;
    bus_idle(); bus.A = 0; bus.din = 0;
    lvbl = 1; dip_pause = 1; dip_flip = 0; rst_n = 0;
    m_reset();
    repeat (3) cyc();
    rst_n = 1;
    cyc();

    // prior writes, then an asynchronous reset in the middle of a cycle
    wr_port(8'h04, 8'h05, 1);
    wr_port(8'h80, 8'h77, 1);
    wr_port(8'h01, 8'h01, 1);
    lvbl = 0; cyc(); lvbl = 1; cyc();
    chk("pre_bank", 32'(bank1), 32'd5);
    #2 rst_n = 0;
    #1;
    chk("rst_bank",   32'(bank1),   32'd0);
    chk("rst_scrpos", 32'(scrpos1), 32'd0);
    chk("rst_scrcol", 32'(scrcol1), 32'd0);
    chk("rst_flip",   32'(flip1),   32'd0);
    chk("rst_int",    32'(int1),    32'd1);
    m_reset();
    @(negedge clk);
    dip_flip = 1;
    bus_wr(8'h04, 8'h07);     // strobe held across release must be ignored
    cyc();
    rst_n = 1;
    cyc(); cyc();
    chk("rst_flip_dip", 32'(flip1), 32'd1);
    cyc();
    chk("rst_held_wr", 32'(bank1), 32'd0);
    bus_idle(); cyc();
    dip_flip = 0;

    // free-running instance: high byte visible two clocks after strobe
    wr_port(8'h81, 8'hFF, 1);
    chk("nolatch_ch0", 32'(scrpos2[8:0]), 32'h100);
    chk("latch_ch0_0", 32'(scrpos1[10:0]), 32'h0);
    cyc(); cyc();

    // atomic scroll commit
    wr_port(8'h80, 8'h34, 1);
    wr_port(8'h81, 8'h05, 1);
    repeat (100) cyc();
    chk("atomic_hold", 32'(scrpos1[10:0]), 32'h0);
    lvbl = 0; cyc();
    chk("atomic_ch0", 32'(scrpos1[10:0]), 32'h534);
    chk("atomic_ch1", 32'(scrpos1[21:11]), 32'h0);
    chk("int_req", 32'(int1), 32'd0);
    bus.m1_n = 0; bus.iorq_n = 0; bus.wr_n = 1; cyc();
    chk("int_ack", 32'(int1), 32'd1);
    bus_idle();
    repeat (5) cyc();
    chk("int_once", 32'(int1), 32'd1);
    lvbl = 1; repeat (3) cyc();

    // long strobe: accepted once even though data changes mid-strobe
    bus_wr(8'h04, 8'hFE);
    repeat (3) cyc();
    bus.din = 8'h01;
    repeat (7) cyc();
    bus_idle(); cyc();
    chk("long_strobe", 32'(bank1), 32'd6);
    wr_port(8'h05, 8'hFF, 2);
    wr_port(8'h85, 8'hFF, 2);
    wr_port(8'h90, 8'hFF, 2);
    chk("unmapped_bank", 32'(bank1), 32'd6);

    // write on the vblank edge commits one frame late; paused => no interrupt
    dip_pause = 0;
    lvbl = 0; bus_wr(8'h82, 8'h11); cyc();
    bus_idle();
    chk("coll_ch1_now", 32'(scrpos1[21:11]), 32'h0);
    chk("pause_int",    32'(int1), 32'd1);
    repeat (4) cyc();
    lvbl = 1; repeat (10) cyc();
    dip_pause = 1;
    lvbl = 0; cyc();
    chk("coll_ch1_next", 32'(scrpos1[21:11]), 32'h011);
    chk("int_req2", 32'(int1), 32'd0);
    repeat (3) cyc();
    lvbl = 1; cyc();
    chk("int_drop", 32'(int1), 32'd1);

    // randomised traffic, every output compared against the model each cycle
    wr_left = 0;
    lv_cnt = 20;
    for (int i = 0; i < 4000; i++) begin
      if (wr_left > 0) begin
        wr_left--;
        if (wr_left == 0) bus_idle();
      end else begin
        case ($urandom % 8)
          0, 1: begin
            bus_wr(($urandom % 6 == 0) ? 8'($urandom) : ports[$urandom % 13], 8'($urandom));
            wr_left = $urandom_range(1, 4);
          end
          2: begin bus.m1_n = 0; bus.iorq_n = 0; bus.wr_n = 1; end
          default: bus_idle();
        endcase
      end
      if (--lv_cnt == 0) begin
        lvbl = ~lvbl;
        lv_cnt = $urandom_range(5, 60);
      end
      if ($urandom % 200 == 0) dip_pause = ~dip_pause;
      if ($urandom % 100 == 0) dip_flip = ~dip_flip;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/jtvigil_ioregs.md
# jtvigil_ioregs

Parametrised Z80 I/O-port register file for the main CPU: decodes I/O writes into a ROM bank register, flip control and N scroll-position channels plus a scroll colour register. Scroll writes land in shadow registers and are committed to the video outputs atomically at vertical-blank start, so mid-frame CPU writes never tear. The block also generates the vertical-blank interrupt with Z80 acknowledge. It sits between the CPU wrapper's bus signals and the tilemap/scroll video units.

## Interface

Parameters:
- SCRN, 2: number of scroll channels (1..8).
- POSW, 11: scroll position width in bits (9..16).
- BANKW, 3: bank register width (1..8).
- VBLATCH, 1: 1 = commit scroll at vblank start; 0 = outputs follow shadow one cycle after the write.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- A  in  8  CPU address, low byte (I/O port number).
- iorq_n  in  1  Z80 IORQ, active low.
- wr_n  in  1  Z80 WR, active low.
- m1_n  in  1  Z80 M1, active low (interrupt acknowledge detect).
- din  in  8  CPU data out.
- LVBL  in  1  vertical blank, active low.
- dip_pause  in  1  1 = running; 0 = paused (interrupts suppressed).
- dip_flip  in  1  external flip inversion.
- bank  out  BANKW  ROM bank select.
- flip  out  1  screen flip.
- scrpos  out  SCRN*POSW  committed scroll positions; channel k at bits [k*POSW +: POSW].
- scrcol  out  3  committed scroll colour.
- int_n  out  1  interrupt request to CPU, active low.

## Operation

- Write strobe: wr_s = !iorq_n && !wr_n && m1_n. Register wr_s each clk; a write is accepted only on the cycle where wr_s=1 and previous wr_s=0. Exactly one register update per bus cycle, regardless of strobe length.
- Port map (on accepted write):
  - A[7]=0, A[2:0]=1: flipr <= din[0].
  - A[7]=0, A[2:0]=4: bank <= din[BANKW-1:0].
  - A[7]=1, A[6:0]=2k (k<SCRN): shadow_k[7:0] <= din; pend[k] <= 1.
  - A[7]=1, A[6:0]=2k+1 (k<SCRN): shadow_k[POSW-1:8] <= din[POSW-9:0]; pend[k] <= 1.
  - A[7]=1, A[6:0]=2*SCRN: colsh <= {din[3], din[1:0]}; pend_col <= 1.
  - Any other port: ignored, no state change.
- Commit (VBLATCH=1): vb_edge = LVBL registered 1 -> now 0. On vb_edge, every channel with pend[k]=1 copies shadow_k to scrpos slice k and clears pend[k]; same for colsh/pend_col. Channels without pending writes keep their value.
- Commit (VBLATCH=0): scrpos/scrcol copy shadow every cycle; pend ignored.
- Write coinciding with vb_edge: commit uses the shadow value before the write; the write updates shadow and leaves pend set, so it commits at the next vblank.
- flip <= flipr ^ dip_flip, registered.
- Interrupt FSM, states IDLE / REQ:
  - IDLE -> REQ on vb_edge when dip_pause=1; int_n=0 in REQ.
  - REQ -> IDLE on acknowledge (!m1_n && !iorq_n), or when LVBL returns to 1 (unacknowledged request dropped), or when dip_pause=0.
  - vb_edge while in REQ: stays in REQ, no double request.
- Reset (rst_n=0, any time, asynchronous): bank=0, flipr=0, flip=0, all shadows, pend bits, scrpos and scrcol = 0, LVBL history = 1, FSM=IDLE, int_n=1. A write in progress at reset release is not accepted unless wr_s is seen low first.

## Timing

- bank, flipr and shadow registers update on the clk edge where the write is accepted, i.e. one clk after wr_s is first sampled high.
- flip: one further clk after flipr/dip_flip change.
- VBLATCH=1: scrpos/scrcol update on the clk edge where vb_edge is detected (first clk with LVBL=0 registered after 1). VBLATCH=0: one clk after shadow.
- int_n falls on the same clk edge as the commit; rises the clk after ack is sampled.
- No combinational path from inputs to outputs.

## Test plan

- Reset: hold rst_n=0 mid-frame with prior writes -> bank=0, scrpos=0, scrcol=0, flip=0, int_n=1; after release with dip_flip=1 -> flip=1 two clks later.
- Atomic scroll (SCRN=2, POSW=11): write port 0x80=0x34, 0x81=0x05, then hold LVBL=1 for 100 clks -> scrpos ch0 stays 0; LVBL falls -> ch0=0x534, ch1 unchanged 0.
- Long strobe: hold iorq_n=wr_n=0 for 10 clks on port 0x04 with din=0xFE -> bank=6, updated once; port 0x05 and 0x85+ (unmapped) leave all state unchanged.
- Collision: write 0x82=0x11 on the exact vb_edge cycle -> ch1 unchanged this frame; ch1[7:0]=0x11 at next vb_edge.
- Interrupt: dip_pause=1, LVBL falls -> int_n=0; assert m1_n=0,iorq_n=0 -> int_n=1 next clk, no second request in same vblank; with dip_pause=0 -> int_n stays 1.
- VBLATCH=0, POSW=9: write 0x81=0xFF -> scrpos ch0=0x100 two clks after strobe, no vblank needed.
